// File: rtl/reset_seq_pkg.sv
// Shared state encoding and parameter defaults
// for the reset sequencer slice.
package reset_seq_pkg;

   localparam int N_CH_DEF      = 4;
   localparam int CNT_W_DEF     = 22;
   localparam int THRESHOLD_DEF = 2000570;
   localparam int PULSE_W_DEF   = 4;
   localparam int STAGGER_DEF   = 16;
   localparam int PERIODIC_DEF  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_ASSERT,
      ST_RELEASE,
      ST_WAIT_LOW
   } seq_state_t;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Trigger request and reset outputs of the sequencer,
// seen from the requester (master) and the sequencer (slave).
interface reset_sequencer_if
   import reset_seq_pkg::*;
#(
   parameter int N_CH = N_CH_DEF
) ();

   logic            trigger_input;
   logic [N_CH-1:0] reset_out;
   logic            busy;
   logic            done;

   modport master (
      output trigger_input,
      input  reset_out,
      input  busy,
      input  done
   );

   modport slave (
      input  trigger_input,
      output reset_out,
      output busy,
      output done
   );

endinterface

// File: rtl/reset_stagger_chain.sv
// Staggered release pattern: channel i clears i*STAGGER
// edges after channel 0, which clears on the start pulse.
module reset_stagger_chain
   import reset_seq_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int STAGGER = STAGGER_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            run,
   output logic [N_CH-1:0] clr,
   output logic            last
);

   localparam int SPAN = (N_CH - 1) * STAGGER;
   localparam int SC_W = clog2_min1(SPAN + 1);

   logic [SC_W-1:0] scnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt <= '0;
      end else if (start) begin
         scnt <= '0;
      end else if (run) begin
         scnt <= scnt + SC_W'(1);
      end
   end

   // clr is the cumulative mask to apply on the coming edge
   always_comb begin
      clr = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (start) begin
            clr[i] = (i * STAGGER == 0);
         end else if (run) begin
            clr[i] = (int'(scnt) + 1 >= i * STAGGER);
         end
      end
   end

   assign last = clr[N_CH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Qualified trigger -> pulse -> staggered per-channel
// reset release; also runs a power-on sequence out of rst.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int N_CH      = N_CH_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int THRESHOLD = THRESHOLD_DEF,
   parameter int PULSE_W   = PULSE_W_DEF,
   parameter int STAGGER   = STAGGER_DEF,
   parameter int PERIODIC  = PERIODIC_DEF
) (
   input logic              clk,
   input logic              rst,
   reset_sequencer_if.slave bus
);

   localparam int PW_W = clog2_min1(PULSE_W);
   localparam logic [CNT_W-1:0] THR_M1 =
      CNT_W'(THRESHOLD - 1);
   localparam logic [PW_W-1:0] PW_M1 =
      PW_W'(PULSE_W - 1);

   if (N_CH < 1) begin : g_bad_nch
      $fatal(1, "N_CH must be at least 1");
   end
   if (PULSE_W < 1) begin : g_bad_pw
      $fatal(1, "PULSE_W must be at least 1");
   end
   if (STAGGER < 0) begin : g_bad_stg
      $fatal(1, "STAGGER must not be negative");
   end
   if (THRESHOLD < 1 ||
       (longint'(THRESHOLD) >> CNT_W) != 0) begin : g_bad_thr
      $fatal(1, "THRESHOLD out of range for CNT_W");
   end

   seq_state_t      state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [PW_W-1:0]  pcnt, pcnt_nx;
   logic [N_CH-1:0]  rout, rout_nx;
   logic [N_CH-1:0]  clr;
   logic             busy_q, done_q, done_nx;
   logic             trig, start, run, last, fin;

   assign trig  = bus.trigger_input;
   assign start = (state == ST_ASSERT) && (pcnt == PW_M1);
   assign run   = (state == ST_RELEASE);

   reset_stagger_chain #(
      .N_CH    (N_CH),
      .STAGGER (STAGGER)
   ) u_chain (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .run   (run),
      .clr   (clr),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_ASSERT;
         cnt    <= '0;
         pcnt   <= '0;
         rout   <= '1;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         pcnt   <= pcnt_nx;
         rout   <= rout_nx;
         busy_q <= |rout_nx;
         done_q <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pcnt_nx  = pcnt;
      rout_nx  = rout;
      done_nx  = 1'b0;
      fin      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_nx  = '0;
            rout_nx = '0;
            if (trig) begin
               if (THR_M1 == '0) begin
                  state_nx = ST_ASSERT;
                  pcnt_nx  = '0;
                  rout_nx  = '1;
               end else begin
                  state_nx = ST_COUNT;
                  cnt_nx   = CNT_W'(1);
               end
            end
         end
         ST_COUNT: begin
            // compare first so the counter can never wrap
            if (!trig) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else if (cnt == THR_M1) begin
               state_nx = ST_ASSERT;
               cnt_nx   = '0;
               pcnt_nx  = '0;
               rout_nx  = '1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         ST_ASSERT: begin
            if (start) begin
               rout_nx = ~clr;
               pcnt_nx = '0;
               fin     = last;
               if (!last) state_nx = ST_RELEASE;
            end else begin
               pcnt_nx = pcnt + PW_W'(1);
            end
         end
         ST_RELEASE: begin
            rout_nx = rout & ~clr;
            fin     = last;
         end
         ST_WAIT_LOW: begin
            if (!trig) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (fin) begin
         done_nx  = 1'b1;
         rout_nx  = '0;
         cnt_nx   = '0;
         state_nx = (PERIODIC != 0 && trig) ?
                    ST_COUNT : ST_WAIT_LOW;
      end
   end

   assign bus.reset_out = rout;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: one-shot and periodic sequencers
// driven by one trigger, expectations from edge timing.
module tb_reset_sequencer;

   localparam int NC  = 4;
   localparam int TH  = 5;
   localparam int PW  = 3;
   localparam int ST  = 2;
   localparam int INF = 1 << 30;

   typedef struct {
      int a;
      int stop;
   } ev_t;

   typedef struct {
      int       e;
      logic [3:0] ro0;
      logic     b0;
      logic     d0;
      logic [3:0] ro1;
      logic     b1;
      logic     d1;
   } exp_t;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic trig = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   ev_t  ev0[$];
   ev_t  ev1[$];
   exp_t mx;

   reset_sequencer_if #(.N_CH(NC)) bus0 ();
   reset_sequencer_if #(.N_CH(NC)) bus1 ();

   assign bus0.trigger_input = trig;
   assign bus1.trigger_input = trig;

   reset_sequencer #(
      .N_CH(NC), .CNT_W(8), .THRESHOLD(TH),
      .PULSE_W(PW), .STAGGER(ST), .PERIODIC(0)
   ) u0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   reset_sequencer #(
      .N_CH(NC), .CNT_W(8), .THRESHOLD(TH),
      .PULSE_W(PW), .STAGGER(ST), .PERIODIC(1)
   ) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   function automatic logic trig_at(input int kind,
                                    input int e);
      case (kind)
         0: return e >= 1 && e <= 5;
         1: return (e >= 1 && e <= 4) ||
                   (e >= 6 && e <= 9);
         2: return e >= 1 && e <= 60;
         3: return (e >= 1 && e <= 5) ||
                   (e >= 6 && e <= 13 && e % 2 == 1);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] exp_ro(input ev_t q[$],
                                         input int e);
      logic [3:0] v;
      v = '0;
      foreach (q[j]) begin
         if (e < q[j].stop) begin
            for (int i = 0; i < NC; i++) begin
               if (e >= q[j].a &&
                   e < q[j].a + PW + i * ST) v[i] = 1'b1;
            end
         end
      end
      return v;
   endfunction

   function automatic logic exp_dn(input ev_t q[$],
                                   input int e);
      logic v;
      v = 1'b0;
      foreach (q[j]) begin
         if (e < q[j].stop &&
             e == q[j].a + PW + (NC - 1) * ST) v = 1'b1;
      end
      return v;
   endfunction

   task automatic push_exp(input int e, input logic r);
      exp_t x;
      x.e = e;
      if (r) begin
         x.ro0 = 4'hF; x.b0 = 1'b1; x.d0 = 1'b0;
         x.ro1 = 4'hF; x.b1 = 1'b1; x.d1 = 1'b0;
      end else begin
         x.ro0 = exp_ro(ev0, e);
         x.b0  = |x.ro0;
         x.d0  = exp_dn(ev0, e);
         x.ro1 = exp_ro(ev1, e);
         x.b1  = |x.ro1;
         x.d1  = exp_dn(ev1, e);
      end
      sb.push_back(x);
   endtask

   task automatic step(input int e, input logic t,
                       input logic r);
      @(negedge clk);
      trig = t;
      rst  = r;
      push_exp(e, r);
   endtask

   task automatic async_chk(input string tag);
      chk({tag, "_ro0"}, 32'(bus0.reset_out), 32'hF);
      chk({tag, "_busy0"}, 32'(bus0.busy), 32'h1);
      chk({tag, "_done0"}, 32'(bus0.done), 32'h0);
      chk({tag, "_ro1"}, 32'(bus1.reset_out), 32'hF);
   endtask

   task automatic run_scen(input int kind,
                           input int e0, input int e1,
                           input int r0, input int r1);
      for (int e = e0; e <= e1; e++) begin
         logic r;
         r = (e >= r0 && e <= r1);
         step(e, trig_at(kind, e), r);
         if (r && e == r0) begin
            #1;
            async_chk($sformatf("k%0d_async@%0d", kind, e));
         end
      end
   endtask

   // compare each popped expectation just after its edge
   initial forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         mx = sb.pop_front();
         chk($sformatf("ro0@%0d", mx.e),
             32'(bus0.reset_out), 32'(mx.ro0));
         chk($sformatf("busy0@%0d", mx.e),
             32'(bus0.busy), 32'(mx.b0));
         chk($sformatf("done0@%0d", mx.e),
             32'(bus0.done), 32'(mx.d0));
         chk($sformatf("ro1@%0d", mx.e),
             32'(bus1.reset_out), 32'(mx.ro1));
         chk($sformatf("busy1@%0d", mx.e),
             32'(bus1.busy), 32'(mx.b1));
         chk($sformatf("done1@%0d", mx.e),
             32'(bus1.done), 32'(mx.d1));
      end
   end

   initial begin
      #1 rst = 1'b1;
      #1 async_chk("por");

      ev0.push_back('{0, INF});
      ev1.push_back('{0, INF});
      run_scen(4, -2, 12, -2, 0);

      ev0.delete(); ev1.delete();
      ev0.push_back('{5, INF});
      ev1.push_back('{5, INF});
      run_scen(0, 1, 20, 1, 0);

      ev0.delete(); ev1.delete();
      run_scen(1, 1, 14, 1, 0);

      ev0.delete(); ev1.delete();
      ev0.push_back('{5, INF});
      ev1.push_back('{5, INF});
      ev1.push_back('{19, INF});
      ev1.push_back('{33, INF});
      ev1.push_back('{47, INF});
      run_scen(2, 1, 70, 1, 0);

      ev0.delete(); ev1.delete();
      ev0.push_back('{5, INF});
      ev1.push_back('{5, INF});
      run_scen(3, 1, 20, 1, 0);

      ev0.delete(); ev1.delete();
      ev0.push_back('{5, 11});
      ev0.push_back('{11, INF});
      ev1.push_back('{5, 11});
      ev1.push_back('{11, INF});
      run_scen(0, 1, 30, 11, 11);

      @(posedge clk);
      #3;
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
